pad_cfg_ctrl: RTL and testbench

PAD_CFG_CTRL -- requirements
Module: pad_cfg_ctrl

---
 rtl/pad_cfg_pkg.sv | 28 ++
 rtl/pad_cfg_side.sv | 42 ++++
 rtl/pad_cfg_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pad_cfg_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pad_cfg_pkg.sv
// Pad configuration controller shared types.
// State/side enums, pad geometry and side base addresses.
package pad_cfg_pkg;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      IDLE  = 2'd1,
      APPLY = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      WE = 2'd0,
      NO = 2'd1,
      EA = 2'd2,
      SO = 2'd3
   } side_e;

   localparam int NUM_SIDES     = 4;
   localparam int PADS_PER_SIDE = 9;
   localparam int CFG_W         = 8;

   localparam logic [5:0] WE_BASE  = 6'd0;
   localparam logic [5:0] NO_BASE  = 6'd9;
   localparam logic [5:0] EA_BASE  = 6'd18;
   localparam logic [5:0] SO_BASE  = 6'd27;
   localparam logic [5:0] ADDR_END = 6'd36;

endpackage

// File: rtl/pad_cfg_side.sv
// One padring side: shadow bank written per pad, active bank copied whole.
// Ports: clk, rst_n, wr_en/wr_idx/wr_data (shadow write), apply_en, cfg.
module pad_cfg_side
   import pad_cfg_pkg::*;
#(
   parameter int PADS = PADS_PER_SIDE,
   parameter int W    = CFG_W,
   parameter int IW   = $clog2(PADS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [IW-1:0]       wr_idx,
   input  logic [W-1:0]        wr_data,
   input  logic                apply_en,
   output logic [PADS*W-1:0]   cfg
);

   logic [PADS*W-1:0] shadow_q;
   logic [PADS*W-1:0] active_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         if (wr_en) begin
            for (int p = 0; p < PADS; p++) begin
               if (wr_idx == IW'(p)) begin
                  shadow_q[p*W +: W] <= wr_data;
               end
            end
         end
         if (apply_en) begin
            active_q <= shadow_q;
         end
      end
   end

   assign cfg = active_q;

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Padring configuration controller: settle hold, shadow writes, 4-cycle apply.
// Ports: clk_i, rst_ni, wr_*, commit_*, force_safe_i, *_cfg_o, pad_safe_o, done_o, err_o.
module pad_cfg_ctrl
   import pad_cfg_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int PADS_PER_SIDE = pad_cfg_pkg::PADS_PER_SIDE,
   parameter int CFG_W         = pad_cfg_pkg::CFG_W
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             wr_valid_i,
   output logic                             wr_ready_o,
   input  logic [5:0]                       wr_addr_i,
   input  logic [CFG_W-1:0]                 wr_data_i,
   input  logic                             commit_valid_i,
   output logic                             commit_ready_o,
   input  logic                             force_safe_i,
   output logic [PADS_PER_SIDE*CFG_W-1:0]   we_cfg_o,
   output logic [PADS_PER_SIDE*CFG_W-1:0]   no_cfg_o,
   output logic [PADS_PER_SIDE*CFG_W-1:0]   ea_cfg_o,
   output logic [PADS_PER_SIDE*CFG_W-1:0]   so_cfg_o,
   output logic                             pad_safe_o,
   output logic                             done_o,
   output logic                             err_o
);

   localparam int IW = $clog2(PADS_PER_SIDE);
   localparam int SW = PADS_PER_SIDE * CFG_W;

   state_e      state_q, state_d;
   side_e       side_q, side_d;
   logic [31:0] cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic          ready;
   logic          wr_acc;
   logic          commit_acc;
   logic          in_range;
   side_e         side_sel;
   logic [IW-1:0] pad_idx;
   logic [3:0]    wr_en;
   logic [3:0]    apply_en;
   logic [SW-1:0] cfg [NUM_SIDES];

   assign ready      = (state_q == IDLE);
   assign wr_acc     = wr_valid_i & ready;
   assign commit_acc = commit_valid_i & ready;
   assign in_range   = (wr_addr_i < ADDR_END);

   // Ranges are disjoint; out-of-range addresses fall in the SO arm
   // but are masked by in_range.
   always_comb begin
      side_sel = WE;
      pad_idx  = '0;
      unique case (1'b1)
         (wr_addr_i >= SO_BASE): begin
            side_sel = SO;
            pad_idx  = IW'(wr_addr_i - SO_BASE);
         end
         (wr_addr_i >= EA_BASE) && (wr_addr_i < SO_BASE): begin
            side_sel = EA;
            pad_idx  = IW'(wr_addr_i - EA_BASE);
         end
         (wr_addr_i >= NO_BASE) && (wr_addr_i < EA_BASE): begin
            side_sel = NO;
            pad_idx  = IW'(wr_addr_i - NO_BASE);
         end
         default: begin
            side_sel = WE;
            pad_idx  = IW'(wr_addr_i - WE_BASE);
         end
      endcase
   end

   always_comb begin
      for (int s = 0; s < NUM_SIDES; s++) begin
         wr_en[s]    = wr_acc & in_range & (side_sel == side_e'(s));
         apply_en[s] = (state_q == APPLY) & (side_q == side_e'(s));
      end
   end

   always_comb begin
      state_d = state_q;
      side_d  = side_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         HOLD: begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q + 32'd1 >= 32'(SETTLE_CYCLES)) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (commit_acc) begin
               state_d = APPLY;
               side_d  = WE;
            end
         end
         APPLY: begin
            side_d = side_e'(side_q + 2'd1);
            if (side_q == SO) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = HOLD;
      endcase
   end

   // An out-of-range write in the commit cycle keeps the flag set.
   always_comb begin
      err_d = err_q;
      if (commit_acc) begin
         err_d = 1'b0;
      end
      if (wr_acc && !in_range) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= HOLD;
         side_q  <= WE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         side_q  <= side_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
      pad_cfg_side #(
         .PADS (PADS_PER_SIDE),
         .W    (CFG_W),
         .IW   (IW)
      ) u_side (
         .clk      (clk_i),
         .rst_n    (rst_ni),
         .wr_en    (wr_en[s]),
         .wr_idx   (pad_idx),
         .wr_data  (wr_data_i),
         .apply_en (apply_en[s]),
         .cfg      (cfg[s])
      );
   end

   assign we_cfg_o       = cfg[WE];
   assign no_cfg_o       = cfg[NO];
   assign ea_cfg_o       = cfg[EA];
   assign so_cfg_o       = cfg[SO];
   assign wr_ready_o     = ready;
   assign commit_ready_o = ready;
   assign pad_safe_o     = (state_q == HOLD) | force_safe_i;
   assign done_o         = done_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Self-checking bench for pad_cfg_ctrl.
// Directed steps plus random traffic against a cycle-level pad model.
module tb_pad_cfg_ctrl;

   localparam int SETTLE = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wv = 1'b0;
   logic        cv = 1'b0;
   logic        fs = 1'b0;
   logic [5:0]  wa = '0;
   logic [7:0]  wd = '0;
   logic        wr_ready, commit_ready, pad_safe, done, err;
   logic [71:0] we_cfg, no_cfg, ea_cfg, so_cfg;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_sh [36];
   logic [7:0] m_ac [36];
   int         hold_left;
   int         apply_left;
   logic       m_err;
   logic       m_done;

   pad_cfg_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .wr_valid_i     (wv),
      .wr_ready_o     (wr_ready),
      .wr_addr_i      (wa),
      .wr_data_i      (wd),
      .commit_valid_i (cv),
      .commit_ready_o (commit_ready),
      .force_safe_i   (fs),
      .we_cfg_o       (we_cfg),
      .no_cfg_o       (no_cfg),
      .ea_cfg_o       (ea_cfg),
      .so_cfg_o       (so_cfg),
      .pad_safe_o     (pad_safe),
      .done_o         (done),
      .err_o          (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] obs,
                      input logic [71:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] side_vec(input int s);
      logic [71:0] v;
      v = '0;
      for (int p = 0; p < 9; p++) v[p*8 +: 8] = m_ac[s*9 + p];
      return v;
   endfunction

   function automatic logic m_ready();
      return (hold_left == 0) && (apply_left == 0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 36; i++) begin
         m_sh[i] = '0;
         m_ac[i] = '0;
      end
      hold_left  = SETTLE;
      apply_left = 0;
      m_err      = 1'b0;
      m_done     = 1'b0;
   endtask

   task automatic model_edge();
      logic wacc, cacc;
      int   s;
      wacc   = wv && m_ready();
      cacc   = cv && m_ready();
      m_done = 1'b0;
      if (apply_left > 0) begin
         s = 4 - apply_left;
         for (int p = 0; p < 9; p++) m_ac[s*9 + p] = m_sh[s*9 + p];
         apply_left--;
         if (apply_left == 0) m_done = 1'b1;
      end
      if (hold_left > 0) hold_left--;
      if (cacc) m_err = 1'b0;
      if (wacc) begin
         if (wa < 6'd36) m_sh[wa] = wd;
         else m_err = 1'b1;
      end
      if (cacc) apply_left = 4;
   endtask

   task automatic check_all();
      chk("we_cfg", we_cfg, side_vec(0));
      chk("no_cfg", no_cfg, side_vec(1));
      chk("ea_cfg", ea_cfg, side_vec(2));
      chk("so_cfg", so_cfg, side_vec(3));
      chk("pad_safe", 72'(pad_safe), 72'((hold_left > 0) || fs));
      chk("wr_ready", 72'(wr_ready), 72'(m_ready()));
      chk("cm_ready", 72'(commit_ready), 72'(m_ready()));
      chk("done", 72'(done), 72'(m_done));
      chk("err", 72'(err), 72'(m_err));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;
      #1;
      check_all();
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!m_ready() && n < 40) begin
         cyc();
         n++;
      end
      chk("wait_ready", 72'(m_ready()), 72'd1);
   endtask

   initial begin
      #2;
      do_reset();
      repeat (SETTLE) cyc();
      chk("settle_rdy", 72'(wr_ready), 72'd1);
      chk("settle_safe", 72'(pad_safe), 72'd0);

      wv = 1'b1; wa = 6'd5; wd = 8'hA5;
      cyc();
      wv = 1'b0; cv = 1'b1;
      cyc();
      cv = 1'b0;
      cyc();
      chk("we_p5_t2", 72'(we_cfg[47:40]), 72'hA5);
      cyc();
      cyc();
      chk("no_done_t4", 72'(done), 72'd0);
      cyc();
      chk("done_t5", 72'(done), 72'd1);
      chk("idle_t5", 72'(wr_ready), 72'd1);

      wv = 1'b1; wa = 6'd40; wd = 8'hFF;
      cyc();
      wv = 1'b0;
      chk("err_set", 72'(err), 72'd1);
      cv = 1'b1;
      cyc();
      cv = 1'b0;
      chk("err_clr", 72'(err), 72'd0);
      wait_ready();

      wv = 1'b1; wa = 6'd35; wd = 8'h3C; cv = 1'b1;
      cyc();
      wv = 1'b0; cv = 1'b0;
      repeat (4) cyc();
      chk("so_p8_t5", 72'(so_cfg[71:64]), 72'h3C);
      chk("done_so", 72'(done), 72'd1);

      wv = 1'b1; wa = 6'd12; wd = 8'h77;
      cyc();
      wv = 1'b0; cv = 1'b1;
      cyc();
      cv = 1'b0;
      cyc();
      do_reset();
      chk("abort_we", we_cfg, 72'd0);
      chk("abort_no", no_cfg, 72'd0);
      cyc();
      chk("abort_nodone", 72'(done), 72'd0);
      wait_ready();
      fs = 1'b1;
      #1;
      check_all();
      chk("force_safe", 72'(pad_safe), 72'd1);
      chk("force_rdy", 72'(wr_ready), 72'd1);
      cv = 1'b1;
      cyc();
      cv = 1'b0;
      repeat (5) cyc();
      fs = 1'b0;

      for (int i = 0; i < 400; i++) begin
         wv = 1'($urandom_range(0, 1));
         wa = 6'($urandom_range(0, 39));
         wd = 8'($urandom);
         cv = ($urandom_range(0, 5) == 0);
         fs = ($urandom_range(0, 4) == 0);
         cyc();
      end
      wv = 1'b0; cv = 1'b0; fs = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
